bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the BRAM word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the BRAM word-address width (depth 2^ADDR_WIDTH).
REQ-003 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid_0 / req_valid_1  in  1  requester N has a request
- req_ready_0 / req_ready_1  out  1  requester N's request is accepted this cycle
- req_write_0 / req_write_1  in  1  1 = write, 0 = read
- req_byte_en_0 / req_byte_en_1  in  DATA_WIDTH/8  write byte enables
- req_addr_0 / req_addr_1  in  ADDR_WIDTH  word address
- req_wdata_0 / req_wdata_1  in  DATA_WIDTH  write data
- resp_valid_0 / resp_valid_1  out  1  read data valid for requester N
- resp_data_0 / resp_data_1  out  DATA_WIDTH  read data
- mem_readEnable  out  1  to BRAM port readEnable
- mem_writeEnable  out  1  to BRAM port writeEnable
- mem_writeByteEnable  out  DATA_WIDTH/8  to BRAM port writeByteEnable
- mem_address  out  ADDR_WIDTH  to BRAM port address
- mem_writeData  out  DATA_WIDTH  to BRAM port writeData
- mem_readData  in  DATA_WIDTH  from BRAM port readData (1-cycle registered read)
- clear_done  out  1  initialization complete; requests may be accepted

Function
REQ-004 The block SHALL share one BRAM port between two requesters, accepting at most one request per cycle, sustaining one request per cycle.
REQ-005 States SHALL be CLEAR (macro only) and RUN; RUN is permanent until reset.
REQ-006 In RUN, with one valid requester, that requester SHALL be granted regardless of priority.
REQ-007 In RUN, with both valid, the requester indicated by a 1-bit priority pointer SHALL be granted.
REQ-008 The pointer SHALL update on each grant to point at the non-granted requester; without a grant it SHALL hold.
REQ-009 req_ready_N SHALL be combinational, high only for the granted requester, low in CLEAR and during reset.
REQ-010 mem_* outputs SHALL combinationally carry the granted request; mem_readEnable = grant & ~write, mem_writeEnable = grant & write.
REQ-011 With no grant in RUN, mem_readEnable and mem_writeEnable SHALL be 0.
REQ-012 A write with all-zero byte enables SHALL be accepted and forwarded unchanged (no memory change).
REQ-013 resp_valid_N SHALL be a register, high exactly one cycle after an accepted read of requester N; writes produce no response.
REQ-014 resp_data_N SHALL equal mem_readData whenever resp_valid_N is high; value otherwise undefined.
REQ-015 Back-to-back reads alternating requesters SHALL yield alternating resp_valid pulses with no lost response.

Reset
REQ-016 On reset low: resp_valid_0/1 = 0, pointer = requester 0, clear counter = 0, clear_done = 0 (macro) or 1 (no macro), state = CLEAR (macro) or RUN.
REQ-017 Reset asserted mid-CLEAR or mid-transaction SHALL abort all activity; any pending response is dropped and CLEAR restarts from address 0.

Configuration
REQ-018 Macro BRAM_ARB_CLEAR_EN SHALL select the power-on clear feature.
REQ-019 With BRAM_ARB_CLEAR_EN: CLEAR writes zero to addresses 0..2^ADDR_WIDTH-1, one per cycle, all byte enables set, then enters RUN with clear_done = 1 the cycle after the last write.
REQ-020 Without BRAM_ARB_CLEAR_EN: no counter or CLEAR state; RUN immediately after reset; clear_done tied 1.

Verification
REQ-021 Both valid every cycle, reads to 0x10 (req 0) and 0x20 (req 1) -> grants alternate 0,1,0,1 starting with 0; each resp_valid one cycle after its grant.
REQ-022 Req 1 alone, write 0xDEADBEEF byte_en 0b0011 to 0x05 over 0x00000000, then read 0x05 -> resp_data_1 = 0x0000BEEF.
REQ-023 Req 0 write 0x11223344 to 0x7, next cycle req 1 read 0x7 -> resp_data_1 = 0x11223344.
REQ-024 With macro, ADDR_WIDTH=4, memory preloaded 0xFF -> req_ready low for 16 cycles, clear_done rises after, every read returns 0x00000000.
REQ-025 With macro, reset asserted at clear cycle 8 then released -> clear restarts at address 0, clear_done after 16 further cycles.
REQ-026 Accepted read followed by reset low next edge -> resp_valid stays 0, pointer back to requester 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter sharing one registered-read BRAM port.
// Define BRAM_ARB_CLEAR_EN to zero every BRAM word after reset before requests are served.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid_0,
  input  logic                    req_valid_1,
  output logic                    req_ready_0,
  output logic                    req_ready_1,
  input  logic                    req_write_0,
  input  logic                    req_write_1,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en_0,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en_1,
  input  logic [ADDR_WIDTH-1:0]   req_addr_0,
  input  logic [ADDR_WIDTH-1:0]   req_addr_1,
  input  logic [DATA_WIDTH-1:0]   req_wdata_0,
  input  logic [DATA_WIDTH-1:0]   req_wdata_1,
  output logic                    resp_valid_0,
  output logic                    resp_valid_1,
  output logic [DATA_WIDTH-1:0]   resp_data_0,
  output logic [DATA_WIDTH-1:0]   resp_data_1,
  output logic                    mem_readEnable,
  output logic                    mem_writeEnable,
  output logic [DATA_WIDTH/8-1:0] mem_writeByteEnable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_writeData,
  input  logic [DATA_WIDTH-1:0]   mem_readData,
  output logic                    clear_done
);

  logic running;
  logic priority1;  // 1: requester 1 wins when both are valid
  logic grant0;
  logic grant1;
  logic respValid0;
  logic respValid1;

`ifdef BRAM_ARB_CLEAR_EN
  // state | meaning
  // CLEAR | zeroing BRAM one word per cycle; requests held off
  // RUN   | arbitrating the two requesters; left only by reset
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clearAddr;
  logic                  clearDone;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clearAddr <= '0;
      clearDone <= 1'b0;
    end else if (state == CLEAR) begin
      clearAddr <= clearAddr + 1'b1;
      if (clearAddr == '1) begin
        state     <= RUN;
        clearDone <= 1'b1;
      end
    end
  end

  assign running    = reset & (state == RUN);
  assign clear_done = clearDone;
`else
  // Reset input gates grants so nothing reaches the BRAM while reset is held.
  assign running    = reset;
  assign clear_done = 1'b1;
`endif

  assign grant0 = running & req_valid_0 & (~req_valid_1 | ~priority1);
  assign grant1 = running & req_valid_1 & (~req_valid_0 | priority1);

  assign req_ready_0 = grant0;
  assign req_ready_1 = grant1;

  always_comb begin
    mem_readEnable      = 1'b0;
    mem_writeEnable     = 1'b0;
    mem_writeByteEnable = '0;
    mem_address         = '0;
    mem_writeData       = '0;
    if (grant0) begin
      mem_readEnable      = ~req_write_0;
      mem_writeEnable     = req_write_0;
      mem_writeByteEnable = req_byte_en_0;
      mem_address         = req_addr_0;
      mem_writeData       = req_wdata_0;
    end else if (grant1) begin
      mem_readEnable      = ~req_write_1;
      mem_writeEnable     = req_write_1;
      mem_writeByteEnable = req_byte_en_1;
      mem_address         = req_addr_1;
      mem_writeData       = req_wdata_1;
    end
`ifdef BRAM_ARB_CLEAR_EN
    if (reset && state == CLEAR) begin
      mem_writeEnable     = 1'b1;
      mem_writeByteEnable = '1;
      mem_address         = clearAddr;
      mem_writeData       = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      priority1  <= 1'b0;
      respValid0 <= 1'b0;
      respValid1 <= 1'b0;
    end else begin
      respValid0 <= grant0 & ~req_write_0;
      respValid1 <= grant1 & ~req_write_1;
      if (grant0) begin
        priority1 <= 1'b1;
      end else if (grant1) begin
        priority1 <= 1'b0;
      end
    end
  end

  // BRAM read is registered, so its output lines up with the response strobe.
  assign resp_valid_0 = respValid0;
  assign resp_valid_1 = respValid1;
  assign resp_data_0  = mem_readData;
  assign resp_data_1  = mem_readData;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed cases plus randomized traffic
// checked against a word-array memory model and round-robin grant model.
module tb_bram_port_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_ARB_CLEAR_EN
  localparam bit          CLEAR_EN = 1'b1;
  localparam logic [DW-1:0] INIT   = 32'hFFFF_FFFF;
`else
  localparam bit          CLEAR_EN = 1'b0;
  localparam logic [DW-1:0] INIT   = 32'h0000_0000;
`endif

  typedef struct packed {
    logic          v;
    logic          w;
    logic [BW-1:0] be;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic req_ready_0, req_ready_1;
  logic req_write_0 = 1'b0, req_write_1 = 1'b0;
  logic [BW-1:0] req_byte_en_0 = '0, req_byte_en_1 = '0;
  logic [AW-1:0] req_addr_0 = '0, req_addr_1 = '0;
  logic [DW-1:0] req_wdata_0 = '0, req_wdata_1 = '0;
  logic resp_valid_0, resp_valid_1;
  logic [DW-1:0] resp_data_0, resp_data_1;
  logic mem_readEnable, mem_writeEnable;
  logic [BW-1:0] mem_writeByteEnable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic [DW-1:0] mem_readData;
  logic clear_done;

  always #5 clock = ~clock;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_write_0(req_write_0), .req_write_1(req_write_1),
    .req_byte_en_0(req_byte_en_0), .req_byte_en_1(req_byte_en_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
    .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
    .mem_writeByteEnable(mem_writeByteEnable), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData),
    .clear_done(clear_done)
  );

  // BRAM with registered read
  logic [DW-1:0] bram [DEPTH] = '{default: INIT};
  always @(posedge clock) begin
    if (mem_writeEnable)
      for (int b = 0; b < BW; b++)
        if (mem_writeByteEnable[b]) bram[mem_address][8*b +: 8] <= mem_writeData[8*b +: 8];
    if (mem_readEnable) mem_readData <= bram[mem_address];
  end

  // Reference model
  logic [DW-1:0] refMem [DEPTH] = '{default: INIT};
  bit   refPtr = 1'b0;
  bit   refRunning = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] cyc = '0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resp_valid_0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp0_unexpected: resp_valid_0 high with no read outstanding (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("resp0_data", resp_data_0, e.data);
          chk("resp0_cycle", cyc, e.cyc);
        end
      end
      if (resp_valid_1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp1_unexpected: resp_valid_1 high with no read outstanding (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("resp1_data", resp_data_1, e.data);
          chk("resp1_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic req_t mk(input logic v, input logic w, input logic [BW-1:0] be,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.v = v; r.w = w; r.be = be; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic req_t randReq();
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), BW'($urandom),
              AW'($urandom_range(0, 15)), $urandom);
  endfunction

  task automatic accept(input req_t r, input bit who);
    exp_t e;
    chk("mem_re", mem_readEnable, !r.w);
    chk("mem_we", mem_writeEnable, r.w);
    chk("mem_addr", mem_address, r.a);
    if (r.w) begin
      chk("mem_be", mem_writeByteEnable, r.be);
      chk("mem_wdata", mem_writeData, r.d);
      for (int b = 0; b < BW; b++)
        if (r.be[b]) refMem[r.a][8*b +: 8] = r.d[8*b +: 8];
    end else begin
      e.data = refMem[r.a];
      e.cyc  = cyc + 1;
      if (who) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic step(input req_t r0, input req_t r1, output logic rd0, output logic rd1);
    bit g0, g1;
    @(posedge clock); #1;
    req_valid_0 = r0.v; req_write_0 = r0.w; req_byte_en_0 = r0.be; req_addr_0 = r0.a; req_wdata_0 = r0.d;
    req_valid_1 = r1.v; req_write_1 = r1.w; req_byte_en_1 = r1.be; req_addr_1 = r1.a; req_wdata_1 = r1.d;
    @(negedge clock);
    g0 = refRunning && r0.v && (!r1.v || refPtr == 1'b0);
    g1 = refRunning && r1.v && (!r0.v || refPtr == 1'b1);
    rd0 = req_ready_0;
    rd1 = req_ready_1;
    chk("ready0", rd0, g0);
    chk("ready1", rd1, g1);
    if (g0) accept(r0, 1'b0);
    else if (g1) accept(r1, 1'b1);
    else begin
      chk("mem_re_idle", mem_readEnable, 0);
      chk("mem_we_idle", mem_writeEnable, 0);
    end
    if (g0) refPtr = 1'b1;
    else if (g1) refPtr = 1'b0;
  endtask

  // Asserts reset now, checks reset state, releases 1 ns after a rising edge.
  task automatic doReset();
    reset = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    refPtr = 1'b0; refRunning = 1'b0;
    @(posedge clock);
    @(negedge clock);
    q0.delete(); q1.delete();
    chk("rst_resp_valid0", resp_valid_0, 0);
    chk("rst_resp_valid1", resp_valid_1, 0);
    chk("rst_clear_done", clear_done, !CLEAR_EN);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1;
    chk("rst_ready0", req_ready_0, 0);
    chk("rst_ready1", req_ready_1, 0);
    chk("rst_mem_we", mem_writeEnable, 0);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    if (CLEAR_EN) refMem = '{default: '0};
    else refRunning = 1'b1;
  endtask

  // Follows the clear sweep from address 0; stopAt < DEPTH returns early at that cycle.
  task automatic clearSeq(input int stopAt);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    for (int i = 0; i < stopAt; i++) begin
      @(negedge clock);
      chk("clr_we", mem_writeEnable, 1);
      chk("clr_re", mem_readEnable, 0);
      chk("clr_addr", mem_address, i);
      chk("clr_wdata", mem_writeData, 0);
      chk("clr_be", mem_writeByteEnable, {BW{1'b1}});
      chk("clr_ready0", req_ready_0, 0);
      chk("clr_ready1", req_ready_1, 0);
      chk("clr_done_low", clear_done, 0);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    if (stopAt == DEPTH) begin
      @(negedge clock);
      chk("clr_done_high", clear_done, 1);
      chk("run_mem_we", mem_writeEnable, 0);
      refRunning = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t idle, r0, r1;
    logic rd0, rd1;
    idle = mk(0, 0, '0, '0, '0);

    doReset();
    if (CLEAR_EN) begin
      clearSeq(8);
      doReset();
      clearSeq(DEPTH);
    end

    // Both requesters reading every cycle: grants alternate from requester 0
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 0, '0, 8'h10, '0), mk(1, 0, '0, 8'h20, '0), rd0, rd1);
      chk("alt_grant0", rd0, (k % 2) == 0);
      chk("alt_grant1", rd1, (k % 2) == 1);
    end

    step(idle, mk(1, 1, 4'b0011, 8'h05, 32'hDEAD_BEEF), rd0, rd1);
    step(idle, mk(1, 0, '0, 8'h05, '0), rd0, rd1);
    step(mk(1, 1, 4'hF, 8'h07, 32'h1122_3344), idle, rd0, rd1);
    step(idle, mk(1, 0, '0, 8'h07, '0), rd0, rd1);
    step(mk(1, 1, 4'b0000, 8'h05, 32'hFFFF_FFFF), idle, rd0, rd1);
    step(mk(1, 0, '0, 8'h05, '0), idle, rd0, rd1);
    step(idle, idle, rd0, rd1);

    // Accepted read immediately followed by reset: response dropped, pointer back to 0
    step(mk(1, 0, '0, 8'h03, '0), idle, rd0, rd1);
    doReset();
    if (CLEAR_EN) clearSeq(DEPTH);
    step(mk(1, 0, '0, 8'h05, '0), mk(1, 0, '0, 8'h07, '0), rd0, rd1);
    chk("ptr_after_reset", rd0, 1);

    r0 = randReq();
    r1 = randReq();
    repeat (500) begin
      step(r0, r1, rd0, rd1);
      if (!r0.v || rd0) r0 = randReq();
      if (!r1.v || rd1) r1 = randReq();
    end

    step(idle, idle, rd0, rd1);
    step(idle, idle, rd0, rd1);
    @(negedge clock);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
